// File: rtl/gf_inverse.sv
// rtl/gf_inverse.sv - sequential GF(2^8) inverter (a^254), optional divide via GF_DIVIDE_EN
module gf_inverse #(
  parameter logic [8:0] MOD_POL = 9'h11B
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
`ifdef GF_DIVIDE_EN
  input  logic [7:0] in_b,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_q,
  output logic       out_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_sq;
  logic [7:0] r_acc;
  logic [2:0] r_cnt;
  logic       r_zero;
  logic       r_in_ready;
  logic       r_out_valid;
  logic [7:0] r_out_q;
  logic       r_out_zero;
`ifdef GF_DIVIDE_EN
  logic [7:0] r_b;
  logic [7:0] w_div;
`endif
  logic [7:0] w_sq2;
  logic [7:0] w_acc_next;

  // Full carry-less 8x8 product followed by reduction of bits 14..8 by MOD_POL
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ ({7'd0, x} << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (p[i]) p = p ^ ({6'd0, MOD_POL} << (i - 8));
    end
    return p[7:0];
  endfunction

  assign w_sq2      = gf_mul(r_sq, r_sq);
  assign w_acc_next = gf_mul(r_acc, w_sq2);
`ifdef GF_DIVIDE_EN
  assign w_div      = gf_mul(r_acc, r_b);
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;
  assign out_zero  = r_out_zero;

  // Control FSM: square-and-multiply over 7 RUN edges, then hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sq        <= 8'h00;
      r_acc       <= 8'h00;
      r_cnt       <= 3'd0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_q     <= 8'h00;
      r_out_zero  <= 1'b0;
`ifdef GF_DIVIDE_EN
      r_b         <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sq       <= in_a;
            r_acc      <= 8'h01;
            r_cnt      <= 3'd0;
            r_zero     <= (in_a == 8'h00);
            r_in_ready <= 1'b0;
`ifdef GF_DIVIDE_EN
            r_b        <= in_b;
`endif
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          // acc accumulates a^(2+4+...+2^k); after 7 steps it holds a^254
          r_sq  <= w_sq2;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd6) begin
`ifdef GF_DIVIDE_EN
            r_state     <= S_DIV;
`else
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_q     <= r_zero ? 8'h00 : w_acc_next;
            r_out_zero  <= r_zero;
`endif
          end
        end
`ifdef GF_DIVIDE_EN
        S_DIV: begin
          r_acc       <= w_div;
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
          r_out_q     <= r_zero ? 8'h00 : w_div;
          r_out_zero  <= r_zero;
        end
`endif
        S_DONE: begin
          // in_ready is registered so it only rises the cycle after the handoff
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_inverse.sv
// tb/tb_gf_inverse.sv - randomized self-checking bench for gf_inverse
module tb_gf_inverse;

`ifdef GF_DIVIDE_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 7;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
`ifdef GF_DIVIDE_EN
  logic [7:0] in_b;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_q;
  logic       out_zero;

  int n_tests = 0;
  int n_fail  = 0;

  gf_inverse #(.MOD_POL(9'h11B)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
`ifdef GF_DIVIDE_EN
    .in_b      (in_b),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference multiply: shift-and-add with xtime reduction (x^8 = x^4+x^3+x+1)
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Reference inverse by exhaustive search for x with a*x == 1
  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (ref_mul(a, 8'(x)) == 8'h01) r = 8'(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_out(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00) return 8'h00;
`ifdef GF_DIVIDE_EN
    return ref_mul(b, ref_inv(a));
`else
    return ref_inv(a);
`endif
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_q, input int hold);
    int cyc;
    logic [7:0] exp_prod;
`ifdef GF_DIVIDE_EN
    exp_prod = b;
`else
    exp_prod = 8'h01;
`endif
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
`ifdef GF_DIVIDE_EN
    in_b = b;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_in_ready_low", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, LAT);
    check("out_q", out_q, exp_q);
    check("out_zero", out_zero, (a == 8'h00));
    if (a != 8'h00) check("product", ref_mul(out_q, a), exp_prod);
    for (int i = 0; i < hold; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        in_a = a ^ 8'h5A;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_q", out_q, exp_q);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
  endtask

  initial begin
    int seen;
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = 8'h00;
`ifdef GF_DIVIDE_EN
    in_b = 8'h00;
`endif
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_q", out_q, 8'h00);
    check("rst_out_zero", out_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known vectors
    do_op(8'h53, 8'h01, 8'hCA, 0);
    do_op(8'h01, 8'h01, 8'h01, 0);
    do_op(8'h02, 8'h01, 8'h8D, 0);
    do_op(8'hCA, 8'h01, 8'h53, 0);
    do_op(8'h00, 8'h37, 8'h00, 0);
`ifdef GF_DIVIDE_EN
    do_op(8'h53, 8'h53, 8'h01, 0);
`endif

    // Result held in DONE with a stray in_valid pulse that must be ignored
    do_op(8'h53, 8'h01, 8'hCA, 5);
    do_op(8'h02, 8'h01, 8'h8D, 0);

    // Abort mid-RUN with reset
    in_valid = 1'b1;
    in_a = 8'h53;
`ifdef GF_DIVIDE_EN
    in_b = 8'h01;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_q", out_q, 8'h00);
    check("abort_out_zero", out_zero, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("abort_no_result", seen, 0);
    do_op(8'h53, 8'h01, 8'hCA, 0);

    // Sweep all nonzero operands back-to-back
    for (int a = 1; a < 256; a++) begin
      rb = 8'($urandom_range(1, 255));
`ifndef GF_DIVIDE_EN
      rb = 8'h01;
`endif
      do_op(8'(a), rb, ref_out(8'(a), rb), 0);
    end

    // Random operands with random consumer stalls
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      if (k % 10 == 0) ra = 8'h00;
      rb = 8'($urandom_range(1, 255));
`ifndef GF_DIVIDE_EN
      rb = 8'h01;
`endif
      do_op(ra, rb, ref_out(ra, rb), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
